// File: rtl/dac_ramp_bank_if.sv
// rtl/dac_ramp_bank_if.sv - register bus between the SPI memory interface and the DAC ramp bank
interface dac_ramp_bank_if #(
    parameter int AWIDTH = 5
) ();
    logic              we;
    logic [AWIDTH-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (output we, output addr, output wdata, input rdata);
    modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/dac_ramp_bank.sv
// rtl/dac_ramp_bank.sv - shadowed DAC channel bank with atomic commit; slew-limited ramp built only with DAC_RAMP_EN
module dac_ramp_bank #(
    parameter int NUM_CH    = 8,
    parameter int DAC_WIDTH = 10,
    parameter int AWIDTH    = 5,
    parameter int DIV_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    dac_ramp_bank_if.slave              bus,
    output logic [NUM_CH*DAC_WIDTH-1:0] dac_out,
    output logic                        busy,
    output logic                        done
);
    localparam logic [AWIDTH-1:0] A_CTRL   = AWIDTH'(NUM_CH);
    localparam logic [AWIDTH-1:0] A_STATUS = AWIDTH'(NUM_CH + 3);

    typedef enum logic {S_IDLE, S_RAMP} state_t;

    state_t               state;
    logic [DAC_WIDTH-1:0] shadow  [NUM_CH];
    logic [DAC_WIDTH-1:0] target  [NUM_CH];
    logic [DAC_WIDTH-1:0] current [NUM_CH];
    logic [NUM_CH-1:0]    settled;
    logic                 ctrl_wr;
    logic                 commit;
    logic [31:0]          rd_next;
    logic                 unused_wdata;

    assign ctrl_wr      = bus.we && (bus.addr == A_CTRL);
    assign commit       = ctrl_wr && bus.wdata[0];
    assign unused_wdata = ^bus.wdata;

    // per-channel settled flags, shared by STATUS and ramp completion
    always_comb begin
        settled = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            settled[k] = (current[k] == target[k]);
        end
    end

    // dac_out is wired straight from the CURRENT flops
    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign dac_out[g*DAC_WIDTH +: DAC_WIDTH] = current[g];
    end

    // shadow registers accept writes in any state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.we && (bus.addr == AWIDTH'(k))) begin
                    shadow[k] <= bus.wdata[DAC_WIDTH-1:0];
                end
            end
        end
    end

`ifdef DAC_RAMP_EN
    localparam logic [AWIDTH-1:0] A_STEP = AWIDTH'(NUM_CH + 1);
    localparam logic [AWIDTH-1:0] A_DIV  = AWIDTH'(NUM_CH + 2);

    logic                 abort;
    logic                 all_settled;
    logic [DAC_WIDTH-1:0] step;
    logic [DAC_WIDTH-1:0] step_eff;
    logic [DIV_WIDTH-1:0] div;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DAC_WIDTH:0]   dist     [NUM_CH];
    logic [DAC_WIDTH-1:0] next_cur [NUM_CH];

    assign abort       = ctrl_wr && bus.wdata[1];
    assign all_settled = &settled;
    assign step_eff    = (step == '0) ? DAC_WIDTH'(1) : step;

    // one step toward target, clamped to the remaining distance so CURRENT never overshoots
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            dist[k]     = '0;
            next_cur[k] = current[k];
            if (target[k] > current[k]) begin
                dist[k]     = {1'b0, target[k]} - {1'b0, current[k]};
                next_cur[k] = (dist[k] > {1'b0, step_eff}) ? current[k] + step_eff : target[k];
            end else if (target[k] < current[k]) begin
                dist[k]     = {1'b0, current[k]} - {1'b0, target[k]};
                next_cur[k] = (dist[k] > {1'b0, step_eff}) ? current[k] - step_eff : target[k];
            end
        end
    end

    // STEP/DIV registers and the IDLE/RAMP controller; ABORT outranks COMMIT, COMMIT outranks a tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            step  <= DAC_WIDTH'(1);
            div   <= '0;
            cnt   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                target[k]  <= '0;
                current[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (bus.we && (bus.addr == A_STEP)) step <= bus.wdata[DAC_WIDTH-1:0];
            if (bus.we && (bus.addr == A_DIV))  div  <= bus.wdata[DIV_WIDTH-1:0];
            case (state)
                S_IDLE: begin
                    if (commit && !abort) begin
                        for (int k = 0; k < NUM_CH; k++) target[k] <= shadow[k];
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RAMP;
                    end
                end
                S_RAMP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (commit) begin
                        for (int k = 0; k < NUM_CH; k++) target[k] <= shadow[k];
                        cnt <= '0;
                    end else if (all_settled) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (cnt == div) begin
                        cnt <= '0;
                        for (int k = 0; k < NUM_CH; k++) current[k] <= next_cur[k];
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    localparam int unused_div_width = DIV_WIDTH;

    // commit jumps every channel straight to its shadow value; busy lasts one cycle then done pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                target[k]  <= '0;
                current[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (commit) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    target[k]  <= shadow[k];
                    current[k] <= shadow[k];
                end
                busy  <= 1'b1;
                state <= S_RAMP;
            end else if (state == S_RAMP) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_IDLE;
            end
        end
    end
`endif

    // read decode; unmapped addresses and CTRL return 0
    always_comb begin
        rd_next = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.addr == AWIDTH'(k)) rd_next = 32'(shadow[k]);
        end
`ifdef DAC_RAMP_EN
        if (bus.addr == A_STEP) rd_next = 32'(step);
        if (bus.addr == A_DIV)  rd_next = 32'(div);
`endif
        if (bus.addr == A_STATUS) rd_next = 32'({settled, busy});
    end

    // read data is registered, one cycle behind addr
    always_ff @(posedge clk) begin
        if (rst) bus.rdata <= '0;
        else     bus.rdata <= rd_next;
    end
endmodule
